hamming_decoder: RTL and testbench

- Byte-serial SECDED decoder/corrector for 16-bit Hamming codewords that carry 11 data bits; the codewords are the ones our ALU's parity/pack ops build.
- Accepts an encoded LSW then an encoded MSW over the 8-bit datapath.
- Computes the syndrome and overall parity, corrects single-bit errors and flags double-bit errors.
- Presents the unpacked 11-bit data as two bytes plus a status code to the downstream register-file/memory write path.

---
 rtl/hamming_decoder.sv | 138 +++++++++++++
 tb/tb_hamming_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// Byte-serial SECDED decoder for 16-bit Hamming codewords carrying 11 data bits.
// Optional error counters are enabled with the HAMMING_ERR_CNT_EN macro.
module hamming_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_lsw,
    output logic [7:0] out_msw,
    output logic [1:0] out_status
`ifdef HAMMING_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_corr_cnt,
    output logic [ERR_CNT_W-1:0] err_dbl_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_MSW = 3'd1,
        SYND    = 3'd2,
        CORR    = 3'd3,
        OUT     = 3'd4
    } state_t;

    localparam logic [1:0] ST_CLEAN  = 2'b00;
    localparam logic [1:0] ST_SINGLE = 2'b01;
    localparam logic [1:0] ST_DOUBLE = 2'b10;

    state_t state, state_nxt;

    logic [15:0] code_p0;
    logic [3:0]  syn_p1;
    logic        par_p1;
    logic [15:0] corr_code;
    logic [10:0] data_c;
    logic [1:0]  status_c;

    function automatic logic [3:0] syndrome(input logic [15:0] code);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (code[i]) s = s ^ 4'(i);
        end
        return s;
    endfunction

    function automatic logic [10:0] extract_data(input logic [15:0] code);
        return {code[15:9], code[7:5], code[3]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = GET_MSW;
            end
            GET_MSW: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SYND;
            end
            SYND: state_nxt = CORR;
            CORR: state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: codeword capture; stage p1: syndrome and overall parity
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid)    code_p0[7:0]  <= in_byte;
        if (state == GET_MSW && in_valid) code_p0[15:8] <= in_byte;
        if (state == SYND) begin
            syn_p1 <= syndrome(code_p0);
            par_p1 <= ^code_p0;
        end
    end

    // Odd overall parity means exactly one flip; syndrome 0 then points at p0 itself
    always_comb begin
        corr_code = code_p0;
        status_c  = ST_CLEAN;
        if (par_p1) begin
            corr_code = code_p0 ^ (16'd1 << syn_p1);
            status_c  = ST_SINGLE;
        end else if (syn_p1 != 4'd0) begin
            status_c  = ST_DOUBLE;
        end
        data_c = extract_data(corr_code);
    end

    // Stage p2: registered result held until the output handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_lsw    <= 8'd0;
            out_msw    <= 8'd0;
            out_status <= ST_CLEAN;
        end else if (state == CORR) begin
            out_lsw    <= data_c[7:0];
            out_msw    <= {5'd0, data_c[10:8]};
            out_status <= status_c;
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    logic out_hs;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_corr_cnt <= '0;
            err_dbl_cnt  <= '0;
        end else if (out_hs) begin
            if (out_status == ST_SINGLE && err_corr_cnt != '1)
                err_corr_cnt <= err_corr_cnt + 1'b1;
            if (out_status == ST_DOUBLE && err_dbl_cnt != '1)
                err_dbl_cnt <= err_dbl_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: hand-computed codewords, latency, backpressure and reset.
module tb_hamming_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_lsw;
    logic [7:0] out_msw;
    logic [1:0] out_status;
`ifdef HAMMING_ERR_CNT_EN
    logic [7:0] err_corr_cnt;
    logic [7:0] err_dbl_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hamming_decoder #(.ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_lsw    (out_lsw),
        .out_msw    (out_msw),
        .out_status (out_status)
`ifdef HAMMING_ERR_CNT_EN
        ,
        .err_corr_cnt (err_corr_cnt),
        .err_dbl_cnt  (err_dbl_cnt)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers LSW then MSW, then checks out_valid rises exactly 3 cycles after the MSW handshake
    task automatic send_word(input string tag, input logic [7:0] lsw, input logic [7:0] msw);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            step();
            waited++;
        end
        check({tag, "_ready_timeout"}, 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_byte  = lsw;
        step();
        check({tag, "_ready_msw"}, 16'(in_ready), 16'd1);
        in_byte  = msw;
        step();
        in_valid = 1'b0;
        in_byte  = 8'h00;
        check({tag, "_valid_n1"}, 16'(out_valid), 16'd0);
        step();
        check({tag, "_valid_n2"}, 16'(out_valid), 16'd0);
        step();
        check({tag, "_valid_n3"}, 16'(out_valid), 16'd1);
    endtask

    task automatic check_out(input string tag, input logic [7:0] lsw, input logic [7:0] msw,
                             input logic [1:0] st);
        check({tag, "_lsw"}, 16'(out_lsw), 16'(lsw));
        check({tag, "_msw"}, 16'(out_msw), 16'(msw));
        check({tag, "_status"}, 16'(out_status), 16'(st));
        check({tag, "_in_ready_out"}, 16'(in_ready), 16'd0);
    endtask

    task automatic accept(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 16'(out_valid), 16'd0);
        check({tag, "_idle_ready"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 16'(out_valid), 16'd0);
        reset = 1'b0;
        step();
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_lsw", 16'(out_lsw), 16'd0);
        check("rst_msw", 16'(out_msw), 16'd0);
        check("rst_status", 16'(out_status), 16'd0);
`ifdef HAMMING_ERR_CNT_EN
        check("rst_corr_cnt", 16'(err_corr_cnt), 16'd0);
        check("rst_dbl_cnt", 16'(err_dbl_cnt), 16'd0);
`endif

        send_word("zero", 8'h00, 8'h00);
        check_out("zero", 8'h00, 8'h00, 2'b00);
        accept("zero");

        send_word("ones", 8'hFF, 8'hFF);
        check_out("ones", 8'hFF, 8'h07, 2'b00);
        accept("ones");

        send_word("flip5", 8'hDF, 8'hFF);
        check_out("flip5", 8'hFF, 8'h07, 2'b01);
        accept("flip5");

        send_word("flip_p0", 8'hFE, 8'hFF);
        check_out("flip_p0", 8'hFF, 8'h07, 2'b01);
        accept("flip_p0");

        send_word("dbl", 8'hDF, 8'hEF);
        check_out("dbl", 8'h7D, 8'h07, 2'b10);
        accept("dbl");
`ifdef HAMMING_ERR_CNT_EN
        check("cnt_corr", 16'(err_corr_cnt), 16'd2);
        check("cnt_dbl", 16'(err_dbl_cnt), 16'd1);
`endif

        // d0 only -> code 0x000F; d10 only -> code 0x8117; d10 with pos 15 flipped
        send_word("d0", 8'h0F, 8'h00);
        check_out("d0", 8'h01, 8'h00, 2'b00);
        accept("d0");

        send_word("d10", 8'h17, 8'h81);
        check_out("d10", 8'h00, 8'h04, 2'b00);
        accept("d10");

        send_word("d10_flip15", 8'h17, 8'h01);
        check_out("d10_flip15", 8'h00, 8'h04, 2'b01);
        accept("d10_flip15");

        // Backpressure: result held, a byte offered meanwhile must not be consumed
        send_word("bp", 8'hDF, 8'hFF);
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid_hold", 16'(out_valid), 16'd1);
            check("bp_lsw_hold", 16'(out_lsw), 16'hFF);
            check("bp_msw_hold", 16'(out_msw), 16'h07);
            check("bp_status_hold", 16'(out_status), 16'd1);
            check("bp_in_ready", 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        check("bp_release_valid", 16'(out_valid), 16'd0);
        check("bp_release_ready", 16'(in_ready), 16'd1);
        send_word("after_bp", 8'hFF, 8'hFF);
        check_out("after_bp", 8'hFF, 8'h07, 2'b00);
        accept("after_bp");
`ifdef HAMMING_ERR_CNT_EN
        check("cnt_corr_bp", 16'(err_corr_cnt), 16'd4);
        check("cnt_dbl_bp", 16'(err_dbl_cnt), 16'd1);
`endif

        // Reset in GET_MSW after LSW 0x55
        in_valid = 1'b1;
        in_byte  = 8'h55;
        step();
        in_valid = 1'b0;
        in_byte  = 8'h00;
        step();
        step();
        check("mid_valid", 16'(out_valid), 16'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 16'(in_ready), 16'd1);
        check("mid_rst_lsw", 16'(out_lsw), 16'd0);
        check("mid_rst_msw", 16'(out_msw), 16'd0);
        check("mid_rst_status", 16'(out_status), 16'd0);
`ifdef HAMMING_ERR_CNT_EN
        check("mid_rst_corr", 16'(err_corr_cnt), 16'd0);
        check("mid_rst_dbl", 16'(err_dbl_cnt), 16'd0);
`endif
        step();
        reset = 1'b0;
        step();
        send_word("post_rst", 8'hFF, 8'hFF);
        check_out("post_rst", 8'hFF, 8'h07, 2'b00);
        accept("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
